// File: rtl/branch_resolve.sv
// Execute-stage control-flow resolver: ID/EX register for branch fields, operand forwarding,
// branch/JAL/JALR resolution, fetch redirect, decode flush and a saturating redirect counter.
module branch_resolve #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall_e,
    input  logic                  i_flush_e,
    input  logic                  i_valid_d,
    input  logic                  i_branch_d,
    input  logic                  i_jump_d,
    input  logic                  i_jalr_d,
    input  logic [2:0]            i_funct3_d,
    input  logic [DATA_WIDTH-1:0] i_pc_d,
    input  logic [DATA_WIDTH-1:0] i_imm_ext_d,
    input  logic [DATA_WIDTH-1:0] i_rd1_d,
    input  logic [DATA_WIDTH-1:0] i_rd2_d,
    input  logic [1:0]            i_forward_a_e,
    input  logic [1:0]            i_forward_b_e,
    input  logic [DATA_WIDTH-1:0] i_result_w,
    input  logic [DATA_WIDTH-1:0] i_alu_result_m,
    output logic [2:0]            o_pc_src_e,
    output logic [DATA_WIDTH-1:0] o_pc_target_e,
    output logic [DATA_WIDTH-1:0] o_jalr_target_e,
    output logic                  o_flush_d,
    output logic                  o_valid_e,
    output logic [CNT_WIDTH-1:0]  o_redirect_count
);

    localparam logic [2:0] PC_SRC_PLUS4 = 3'b000;
    localparam logic [2:0] PC_SRC_TGT   = 3'b001;
    localparam logic [2:0] PC_SRC_JALR  = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic                  r_valid_e;
    logic                  r_branch_e;
    logic                  r_jump_e;
    logic                  r_jalr_e;
    logic [2:0]            r_funct3_e;
    logic [DATA_WIDTH-1:0] r_pc_e;
    logic [DATA_WIDTH-1:0] r_imm_e;
    logic [DATA_WIDTH-1:0] r_rd1_e;
    logic [DATA_WIDTH-1:0] r_rd2_e;
    logic [CNT_WIDTH-1:0]  r_redirect_cnt;

    logic [DATA_WIDTH-1:0] w_src_a;
    logic [DATA_WIDTH-1:0] w_src_b;
    logic [DATA_WIDTH-1:0] w_jalr_sum;
    logic                  w_cond;
    logic                  w_taken;

    always_comb begin
        case (i_forward_a_e)
            2'b01:   w_src_a = i_result_w;
            2'b10:   w_src_a = i_alu_result_m;
            default: w_src_a = r_rd1_e;
        endcase
        case (i_forward_b_e)
            2'b01:   w_src_b = i_result_w;
            2'b10:   w_src_b = i_alu_result_m;
            default: w_src_b = r_rd2_e;
        endcase
    end

    always_comb begin
        case (r_funct3_e)
            F3_BEQ:  w_cond = (w_src_a == w_src_b);
            F3_BNE:  w_cond = (w_src_a != w_src_b);
            F3_BLT:  w_cond = ($signed(w_src_a) <  $signed(w_src_b));
            F3_BGE:  w_cond = ($signed(w_src_a) >= $signed(w_src_b));
            F3_BLTU: w_cond = (w_src_a <  w_src_b);
            F3_BGEU: w_cond = (w_src_a >= w_src_b);
            default: w_cond = 1'b0;
        endcase
    end

    // A stalled instruction must not redirect; it resolves once the stall drops.
    assign w_taken = r_valid_e & ~i_stall_e & (r_jump_e | r_jalr_e | (r_branch_e & w_cond));

    always_comb begin
        o_pc_src_e = PC_SRC_PLUS4;
        if (w_taken) begin
            o_pc_src_e = r_jalr_e ? PC_SRC_JALR : PC_SRC_TGT;
        end
    end

    assign w_jalr_sum       = w_src_a + r_imm_e;
    assign o_pc_target_e    = r_pc_e + r_imm_e;
    assign o_jalr_target_e  = {w_jalr_sum[DATA_WIDTH-1:1], 1'b0};
    assign o_flush_d        = w_taken;
    assign o_valid_e        = r_valid_e;
    assign o_redirect_count = r_redirect_cnt;

    // ID/EX register; a redirect bubbles the wrong-path instruction entering E.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid_e  <= 1'b0;
            r_branch_e <= 1'b0;
            r_jump_e   <= 1'b0;
            r_jalr_e   <= 1'b0;
            r_funct3_e <= 3'b000;
            r_pc_e     <= '0;
            r_imm_e    <= '0;
            r_rd1_e    <= '0;
            r_rd2_e    <= '0;
        end else if (i_flush_e || w_taken) begin
            r_valid_e  <= 1'b0;
            r_branch_e <= 1'b0;
            r_jump_e   <= 1'b0;
            r_jalr_e   <= 1'b0;
        end else if (!i_stall_e) begin
            r_valid_e  <= i_valid_d;
            r_branch_e <= i_branch_d;
            r_jump_e   <= i_jump_d;
            r_jalr_e   <= i_jalr_d;
            r_funct3_e <= i_funct3_d;
            r_pc_e     <= i_pc_d;
            r_imm_e    <= i_imm_ext_d;
            r_rd1_e    <= i_rd1_d;
            r_rd2_e    <= i_rd2_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_cnt <= '0;
        end else if (w_taken && (r_redirect_cnt != {CNT_WIDTH{1'b1}})) begin
            r_redirect_cnt <= r_redirect_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: per-cycle comparison against a behavioural model of the
// execute slot, plus literal expectations for the hand-worked scenarios.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        stall_e, flush_e;
    logic        valid_d, branch_d, jump_d, jalr_d;
    logic [2:0]  funct3_d;
    logic [31:0] pc_d, imm_d, rd1_d, rd2_d;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] result_w, alu_m;
    logic [2:0]  pc_src;
    logic [31:0] pc_target, jalr_target;
    logic        flush_d, valid_e;
    logic [3:0]  redirect_count;

    int n_checks = 0;
    int n_err    = 0;

    branch_resolve #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (4)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stall_e        (stall_e),
        .i_flush_e        (flush_e),
        .i_valid_d        (valid_d),
        .i_branch_d       (branch_d),
        .i_jump_d         (jump_d),
        .i_jalr_d         (jalr_d),
        .i_funct3_d       (funct3_d),
        .i_pc_d           (pc_d),
        .i_imm_ext_d      (imm_d),
        .i_rd1_d          (rd1_d),
        .i_rd2_d          (rd2_d),
        .i_forward_a_e    (fwd_a),
        .i_forward_b_e    (fwd_b),
        .i_result_w       (result_w),
        .i_alu_result_m   (alu_m),
        .o_pc_src_e       (pc_src),
        .o_pc_target_e    (pc_target),
        .o_jalr_target_e  (jalr_target),
        .o_flush_d        (flush_d),
        .o_valid_e        (valid_e),
        .o_redirect_count (redirect_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the instruction sitting in execute and the redirect tally.
    typedef struct {
        bit          v, br, j, jr;
        bit [2:0]    f3;
        bit [31:0]   pc, imm, rd1, rd2;
    } slot_t;

    slot_t    m_e;
    bit [3:0] m_cnt;

    function automatic bit [31:0] pick(input bit [1:0] sel, input bit [31:0] reg_val);
        if (sel == 2'd1) return result_w;
        if (sel == 2'd2) return alu_m;
        return reg_val;
    endfunction

    function automatic bit branch_holds(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_taken();
        bit [31:0] a, b;
        a = pick(fwd_a, m_e.rd1);
        b = pick(fwd_b, m_e.rd2);
        if (!m_e.v || stall_e) return 1'b0;
        return m_e.j || m_e.jr || (m_e.br && branch_holds(m_e.f3, a, b));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e   <= '{default: '0};
            m_cnt <= 4'd0;
        end else begin
            if (model_taken() && m_cnt != 4'd15) m_cnt <= m_cnt + 4'd1;
            if (flush_e || model_taken()) begin
                m_e.v  <= 1'b0;
                m_e.br <= 1'b0;
                m_e.j  <= 1'b0;
                m_e.jr <= 1'b0;
            end else if (!stall_e) begin
                m_e <= '{v: valid_d, br: branch_d, j: jump_d, jr: jalr_d, f3: funct3_d,
                         pc: pc_d, imm: imm_d, rd1: rd1_d, rd2: rd2_d};
            end
        end
    end

    always @(negedge clk) begin
        bit        tk;
        bit [31:0] a;
        if (!rst_n) begin
            chk("rst_valid", {31'd0, valid_e}, 32'd0);
            chk("rst_pc_src", {29'd0, pc_src}, 32'd0);
            chk("rst_flush", {31'd0, flush_d}, 32'd0);
            chk("rst_count", {28'd0, redirect_count}, 32'd0);
            chk("rst_target", pc_target, 32'd0);
        end else begin
            tk = model_taken();
            a  = pick(fwd_a, m_e.rd1);
            chk("m_valid", {31'd0, valid_e}, {31'd0, m_e.v});
            chk("m_pc_src", {29'd0, pc_src}, tk ? (m_e.jr ? 32'd2 : 32'd1) : 32'd0);
            chk("m_flush_d", {31'd0, flush_d}, {31'd0, tk});
            chk("m_count", {28'd0, redirect_count}, {28'd0, m_cnt});
            if (m_e.v) begin
                chk("m_pc_target", pc_target, m_e.pc + m_e.imm);
                chk("m_jalr_target", jalr_target, (a + m_e.imm) & ~32'd1);
            end
        end
    end

    task automatic drive_d(input logic v, input logic br, input logic j, input logic jr,
                           input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] r1, input logic [31:0] r2);
        valid_d  = v;
        branch_d = br;
        jump_d   = j;
        jalr_d   = jr;
        funct3_d = f3;
        pc_d     = pc;
        imm_d    = imm;
        rd1_d    = r1;
        rd2_d    = r2;
    endtask

    task automatic nop();
        drive_d(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h4, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stall_e  = 1'b0;
        flush_e  = 1'b0;
        fwd_a    = 2'd0;
        fwd_b    = 2'd0;
        result_w = 32'hDEAD_BEEF;
        alu_m    = 32'h1234_5678;
        drive_d(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_valid", {31'd0, valid_e}, 32'd0);
        chk("reset_pc_src", {29'd0, pc_src}, 32'd0);
        chk("reset_target", pc_target, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // BEQ taken
        drive_d(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
        tick();
        nop();
        @(negedge clk);
        chk("beq_pc_src", {29'd0, pc_src}, 32'd1);
        chk("beq_target", pc_target, 32'h120);
        chk("beq_flush_d", {31'd0, flush_d}, 32'd1);
        tick();
        @(negedge clk);
        chk("beq_bubble", {31'd0, valid_e}, 32'd0);
        chk("beq_count", {28'd0, redirect_count}, 32'd1);

        // BLT taken (-1 < 1), then BLTU not taken
        drive_d(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        tick();
        nop();
        @(negedge clk);
        chk("blt_pc_src", {29'd0, pc_src}, 32'd1);
        chk("blt_target", pc_target, 32'h240);
        tick();
        drive_d(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        tick();
        nop();
        @(negedge clk);
        chk("bltu_pc_src", {29'd0, pc_src}, 32'd0);
        chk("bltu_flush_d", {31'd0, flush_d}, 32'd0);
        tick();
        @(negedge clk);
        chk("bltu_count", {28'd0, redirect_count}, 32'd2);

        // JALR, then the same slot with ALUResultM forwarded into SrcA
        drive_d(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h300, 32'h0, 32'h203, 32'h0);
        tick();
        nop();
        #1;
        chk("jalr_pc_src", {29'd0, pc_src}, 32'd2);
        chk("jalr_target", jalr_target, 32'h202);
        fwd_a = 2'd2;
        alu_m = 32'h401;
        @(negedge clk);
        chk("jalr_fwd_target", jalr_target, 32'h400);
        tick();
        fwd_a = 2'd0;
        @(negedge clk);
        chk("jalr_count", {28'd0, redirect_count}, 32'd3);

        // Taken BNE held by a 3-cycle stall
        drive_d(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'h400, 32'h8, 32'd1, 32'd2);
        tick();
        stall_e = 1'b1;
        nop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc_src", {29'd0, pc_src}, 32'd0);
            chk("stall_flush_d", {31'd0, flush_d}, 32'd0);
            tick();
        end
        stall_e = 1'b0;
        @(negedge clk);
        chk("unstall_pc_src", {29'd0, pc_src}, 32'd1);
        chk("unstall_count_before", {28'd0, redirect_count}, 32'd3);
        tick();
        @(negedge clk);
        chk("unstall_count_after", {28'd0, redirect_count}, 32'd4);

        // JAL with wrapping target
        drive_d(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0);
        tick();
        nop();
        @(negedge clk);
        chk("jal_wrap_pc_src", {29'd0, pc_src}, 32'd1);
        chk("jal_wrap_target", pc_target, 32'h10);
        tick();

        // FlushE kills a taken branch entering E
        drive_d(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h500, 32'h4, 32'd7, 32'd7);
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        nop();
        @(negedge clk);
        chk("flushe_valid", {31'd0, valid_e}, 32'd0);
        chk("flushe_pc_src", {29'd0, pc_src}, 32'd0);
        tick();

        // FlushE and StallE together: flush wins over holding the valid nop
        drive_d(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h500, 32'h4, 32'd7, 32'd7);
        flush_e = 1'b1;
        stall_e = 1'b1;
        tick();
        flush_e = 1'b0;
        stall_e = 1'b0;
        nop();
        @(negedge clk);
        chk("flush_stall_valid", {31'd0, valid_e}, 32'd0);

        // Bubble carrying a stale branch bit never redirects
        drive_d(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h600, 32'h4, 32'd7, 32'd7);
        tick();
        nop();
        @(negedge clk);
        chk("stale_pc_src", {29'd0, pc_src}, 32'd0);
        chk("stale_flush_d", {31'd0, flush_d}, 32'd0);
        tick();
        @(negedge clk);
        chk("stale_count", {28'd0, redirect_count}, 32'd5);

        // JAL and JALR both set: JALR select wins
        drive_d(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h700, 32'h10, 32'h55, 32'h0);
        tick();
        nop();
        @(negedge clk);
        chk("both_pc_src", {29'd0, pc_src}, 32'd2);
        chk("both_jalr_target", jalr_target, 32'h64);
        tick();

        // Asynchronous reset in the middle of a redirect
        drive_d(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h800, 32'h8, 32'h0, 32'h0);
        tick();
        nop();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc_src", {29'd0, pc_src}, 32'd0);
        chk("arst_flush_d", {31'd0, flush_d}, 32'd0);
        chk("arst_count", {28'd0, redirect_count}, 32'd0);
        chk("arst_valid", {31'd0, valid_e}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 20 redirects into a 4-bit counter: saturates at 15
        drive_d(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h900, 32'h8, 32'h0, 32'h0);
        for (int i = 0; i < 40; i++) tick();
        nop();
        @(negedge clk);
        chk("sat_count", {28'd0, redirect_count}, 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
